lsu: RTL and testbench
======================

# lsu

Load/store unit for the multi-cycle RV64 core: sits between the execute stage and the data bus. It takes the ALU-computed address, store operand and access-type code from the control path, runs one `dbus` transaction, and returns a sign/zero-extended load result plus a one-cycle `finish` pulse to the control unit. It holds the request stable for the whole bus handshake and never issues twice for one held request.

## Interface
- Parameters: none.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low.
- `re`  in  1  load request, level; held by control unit during memory phase.
- `we`  in  1  store request, level; `we` wins if both high.
- `addr`  in  64  byte address (ALU result).
- `wdata`  in  64  store operand (rs2), value in low bits.
- `info`  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 treated as D.
- `dreq`  out  dbus_req_t  `valid`, `addr`, `size` (MSIZE1/2/4/8), `strobe[7:0]`, `data[63:0]`.
- `dresp`  in  dbus_resp_t  `data_ok`, `data[63:0]` (`addr_ok` ignored).
- `rdata`  out  64  extended load result.
- `finish`  out  1  one-cycle completion pulse.
- `misalign`  out  1  valid with `finish`; access was misaligned and not issued.

## Operation
- FSM states: IDLE, BUS, DONE, HOLD.
- IDLE: if `re|we`, latch `addr`, `wdata`, `info`, op (store if `we`); go BUS (or DONE with `misalign` under the config macro).
- BUS: `dreq.valid=1`; payload from latched regs, constant. On `data_ok`: capture extended load data into `rdata` (store: `rdata` unchanged); go DONE.
- DONE: `finish=1` one cycle; go HOLD if `re|we` still high, else IDLE.
- HOLD: wait until `re==0 && we==0`, then IDLE. No request issued.
- Address: `dreq.addr` = latched addr unmodified. Offset `o = addr[2:0]`.
- Size: B→MSIZE1, H→MSIZE2, W→MSIZE4, D→MSIZE8.
- Store: `data = wdata << (8*o)`; `strobe` = {1,3,0xF,0xFF} per size, `<< o`, truncated to 8 bits. Load: `strobe=0`.
- Load extract: `t = dresp.data >> (8*o)`; B/H/W sign-extend bit 7/15/31; BU/HU/WU zero-extend; D = `t`.
- Signed shifts are never used; all shifts logical, 64-bit.

## Timing
- Reset (`rst==0` at edge): state IDLE, `dreq.valid=0`, `dreq.addr/data/strobe/size=0`, `rdata=0`, `finish=0`, `misalign=0`. Applies mid-transaction; in-flight access is abandoned, `valid` drops next cycle.
- `dreq` registered: request seen in IDLE at edge N → `valid=1` in cycle N+1.
- `data_ok` in cycle N+1 → `finish` and `rdata` valid in cycle N+2. Minimum latency 2 cycles; each stall cycle adds 1.
- `valid` and payload stay constant from first cycle until the cycle `data_ok` is seen; `valid=0` in DONE.
- `data_ok` outside BUS ignored.
- `rdata` holds its value until the next load completes.
- Input changes after latching (cycle N onward) have no effect on the current access.
- Back-to-back: request dropped in DONE cycle → next request accepted earliest in the cycle after DONE.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: in IDLE, H with `o[0]!=0`, W with `o[1:0]!=0`, D with `o!=0` skip BUS; DONE next cycle with `finish=1`, `misalign=1`, `rdata` unchanged, no bus activity.
- Undefined: no check; every access issued as computed (strobe truncated); `misalign` tied 0.

## Test plan
- LB at `0x80000003`, `dresp.data=0x0000_0000_8000_0000`, `data_ok` in first BUS cycle → `strobe=0`, `size=MSIZE1`, `finish` 2 cycles after request, `rdata=0xFFFF_FFFF_FFFF_FF80`.
- LHU at `0x80000006`, `dresp.data=0xBEEF_0000_0000_0000`, `data_ok` after 3 stall cycles → `valid` stable 4 cycles, `rdata=0x0000_0000_0000_BEEF`, `finish` one pulse.
- SW at `0x80000004`, `wdata=0x1234_5678` → `strobe=0xF0`, `data=0x1234_5678_0000_0000`, `size=MSIZE4`; `re/we` held 5 more cycles → exactly one `valid` burst.
- `re` and `we` both high, SD at `0x80000000` → store issued, `strobe=0xFF`.
- `rst` low during BUS stall → next cycle `valid=0`, state IDLE, `finish` never pulses.
- With `LSU_MISALIGN_CHECK_EN`: LW at `0x80000002` → no `valid`, `finish=1` and `misalign=1` one cycle after request; without macro → issued with `strobe=0x3C`.

Source files
------------

// File: rtl/lsu.sv
// lsu: RV64 load/store unit driving one dbus transaction per held request.
// LSU_MISALIGN_CHECK_EN: misaligned H/W/D accesses finish with misalign set instead of issuing.
package lsu_pkg;
  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [2:0]  info,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic [63:0] rdata,
  output logic        finish,
  output logic        misalign
);
  typedef enum logic [1:0] {IDLE, BUS, DONE, HOLD} state_t;
  state_t state;
  logic [2:0] i_q;
  logic st_q;
  logic mis;
  logic unused;
  logic [7:0] smask;
  logic [63:0] t;
  logic [63:0] ext;
  assign unused = dresp.addr_ok;
  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (info[1:0] == 2'd1 && addr[0]) || (info[1:0] == 2'd2 && addr[1:0] != 2'd0) ||
          (info[1:0] == 2'd3 && addr[2:0] != 3'd0);
`else
    mis = 1'b0;
`endif
    smask = info[1:0] == 2'd0 ? 8'h01 : info[1:0] == 2'd1 ? 8'h03 : info[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    t = dresp.data >> {dreq.addr[2:0], 3'b000};
    ext = i_q == 3'b000 ? {{56{t[7]}}, t[7:0]} :
          i_q == 3'b001 ? {{48{t[15]}}, t[15:0]} :
          i_q == 3'b010 ? {{32{t[31]}}, t[31:0]} :
          i_q == 3'b100 ? {56'd0, t[7:0]} :
          i_q == 3'b101 ? {48'd0, t[15:0]} :
          i_q == 3'b110 ? {32'd0, t[31:0]} : t;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      dreq <= '0;
      rdata <= '0;
      finish <= 1'b0;
      misalign <= 1'b0;
      i_q <= '0;
      st_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (re | we) begin
          i_q <= info;
          st_q <= we;
          if (mis) begin
            state <= DONE;
            finish <= 1'b1;
            misalign <= 1'b1;
          end else begin
            state <= BUS;
            dreq.valid <= 1'b1;
            dreq.addr <= addr;
            dreq.size <= msize_t'(info[1:0]);
            dreq.strobe <= we ? smask << addr[2:0] : 8'h00;
            dreq.data <= we ? wdata << {addr[2:0], 3'b000} : 64'd0;
          end
        end
        BUS: if (dresp.data_ok) begin
          dreq.valid <= 1'b0;
          finish <= 1'b1;
          state <= DONE;
          if (!st_q) rdata <= ext;
        end
        DONE: begin
          finish <= 1'b0;
          misalign <= 1'b0;
          state <= (re | we) ? HOLD : IDLE;
        end
        HOLD: if (!(re | we)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu; honours LSU_MISALIGN_CHECK_EN.
module tb_lsu;
  import lsu_pkg::*;
  logic clk = 0, rst = 0, re = 0, we = 0;
  logic [63:0] addr = 0, wdata = 0;
  logic [2:0] info = 0;
  dbus_req_t dreq;
  dbus_resp_t dresp = '0;
  logic [63:0] rdata;
  logic finish, misalign;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  lsu dut (.clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata), .info(info),
           .dreq(dreq), .dresp(dresp), .rdata(rdata), .finish(finish), .misalign(misalign));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", dreq.valid, 0);
    chk("rst_addr", dreq.addr, 0);
    chk("rst_strobe", dreq.strobe, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_finish", finish, 0);
    chk("rst_misalign", misalign, 0);
    rst = 1;
    tick();
    // LB with data_ok already high in the first bus cycle
    re = 1; addr = 64'h8000_0003; info = 3'b000;
    dresp.data = 64'h0000_0000_8000_0000; dresp.data_ok = 1;
    tick();
    chk("lb_valid", dreq.valid, 1);
    chk("lb_strobe", dreq.strobe, 0);
    chk("lb_size", dreq.size, MSIZE1);
    chk("lb_addr", dreq.addr, 64'h8000_0003);
    chk("lb_nofinish", finish, 0);
    tick();
    chk("lb_finish", finish, 1);
    chk("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_valid_done", dreq.valid, 0);
    re = 0; dresp.data_ok = 0;
    tick();
    chk("lb_finish_drop", finish, 0);
    // LHU with three stall cycles; inputs changed after latching
    re = 1; addr = 64'h8000_0006; info = 3'b101; dresp.data = 64'hBEEF_0000_0000_0000;
    tick();
    addr = 64'h1234; info = 3'b011;
    for (int i = 0; i < 3; i++) begin
      chk("lhu_stall_valid", dreq.valid, 1);
      chk("lhu_stall_addr", dreq.addr, 64'h8000_0006);
      chk("lhu_stall_size", dreq.size, MSIZE2);
      chk("lhu_stall_finish", finish, 0);
      tick();
    end
    chk("lhu_valid4", dreq.valid, 1);
    dresp.data_ok = 1;
    tick();
    chk("lhu_finish", finish, 1);
    chk("lhu_rdata", rdata, 64'h0000_0000_0000_BEEF);
    tick();
    chk("lhu_pulse", finish, 0);
    chk("lhu_hold_valid", dreq.valid, 0);
    tick();
    chk("lhu_hold_valid2", dreq.valid, 0);
    re = 0; dresp.data_ok = 0;
    tick();
    // SW held for five more cycles after completion
    we = 1; addr = 64'h8000_0004; info = 3'b010; wdata = 64'h1234_5678;
    tick();
    chk("sw_valid", dreq.valid, 1);
    chk("sw_strobe", dreq.strobe, 8'hF0);
    chk("sw_data", dreq.data, 64'h1234_5678_0000_0000);
    chk("sw_size", dreq.size, MSIZE4);
    dresp.data_ok = 1;
    tick();
    chk("sw_finish", finish, 1);
    chk("sw_rdata_kept", rdata, 64'h0000_0000_0000_BEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sw_hold_valid", dreq.valid, 0);
      chk("sw_hold_finish", finish, 0);
    end
    we = 0; dresp.data_ok = 0;
    tick();
    // re and we together: store wins
    re = 1; we = 1; addr = 64'h8000_0000; info = 3'b011; wdata = 64'hAABB_CCDD_1122_3344;
    tick();
    chk("sd_strobe", dreq.strobe, 8'hFF);
    chk("sd_data", dreq.data, 64'hAABB_CCDD_1122_3344);
    chk("sd_size", dreq.size, MSIZE8);
    dresp.data_ok = 1;
    tick();
    chk("sd_finish", finish, 1);
    chk("sd_rdata_kept", rdata, 64'h0000_0000_0000_BEEF);
    re = 0; we = 0; dresp.data_ok = 0;
    tick();
    // reset during a bus stall
    re = 1; addr = 64'h8000_0010; info = 3'b000;
    tick();
    chk("rstbus_valid", dreq.valid, 1);
    rst = 0;
    tick();
    chk("rstbus_valid_drop", dreq.valid, 0);
    chk("rstbus_rdata", rdata, 0);
    rst = 1; re = 0; dresp.data_ok = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstbus_nofinish", finish, 0);
      chk("rstbus_novalid", dreq.valid, 0);
    end
    dresp.data_ok = 0;
    // misaligned LW
    re = 1; addr = 64'h8000_0002; info = 3'b010; dresp.data = 64'h1111_8765_4321_0000;
    tick();
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_valid", dreq.valid, 0);
    chk("mis_finish", finish, 1);
    chk("mis_flag", misalign, 1);
    chk("mis_rdata", rdata, 0);
    tick();
    chk("mis_pulse", finish, 0);
    chk("mis_flag_drop", misalign, 0);
`else
    chk("lw_valid", dreq.valid, 1);
    chk("lw_strobe", dreq.strobe, 0);
    chk("lw_size", dreq.size, MSIZE4);
    dresp.data_ok = 1;
    tick();
    chk("lw_finish", finish, 1);
    chk("lw_misalign", misalign, 0);
    chk("lw_rdata", rdata, 64'hFFFF_FFFF_8765_4321);
    re = 0; dresp.data_ok = 0;
    tick();
    we = 1; wdata = 64'hCAFE_F00D;
    tick();
    chk("sw_mis_strobe", dreq.strobe, 8'h3C);
    chk("sw_mis_data", dreq.data, 64'h0000_CAFE_F00D_0000);
    dresp.data_ok = 1;
    tick();
    chk("sw_mis_finish", finish, 1);
`endif
    re = 0; we = 0; dresp.data_ok = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
